// File: rtl/clock24_pkg.sv
// Shared types and BCD helpers for the clock24 design.
// The alarm FSM states live here so the time-set FSM can share the same style.
package clock24_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETMIN,
    ST_SETHOUR,
    ST_RING,
    ST_SNOOZE
  } alarm_state_t;

  localparam logic [7:0] BCD_MIN_MAX  = 8'h59;
  localparam logic [7:0] BCD_HOUR_MAX = 8'h23;

  // Increment a two-digit BCD value, wrapping to 00 after max.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max)
      return 8'h00;
    else if (v[3:0] == 4'h9)
      return {v[7:4] + 4'h1, 4'h0};
    else
      return {v[7:4], v[3:0] + 4'h1};
  endfunction

endpackage

// File: rtl/alarm_timer.sv
// Loadable saturating down-counter shared by the ring and snooze phases.
// LOAD wins over EN; the count sticks at zero instead of wrapping.
module alarm_timer #(
  parameter int W = 9
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         LOAD,
  input  logic [W-1:0] VALUE,
  input  logic         EN,
  output logic [W-1:0] COUNT,
  output logic         ZERO
);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      COUNT <= '0;
    else if (LOAD)
      COUNT <= VALUE;
    else if (EN && (COUNT != '0))
      COUNT <= COUNT - 1'b1;
  end

  assign ZERO = (COUNT == '0);

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: alarm time registers, set-mode sequencing with blink,
// alarm match detection, and ring / snooze sequencing of the buzzer.
module alarm_ctrl
  import clock24_pkg::*;
#(
  parameter int         RING_SEC   = 60,
  parameter int         SNOOZE_MIN = 5,
  parameter logic [7:0] RST_HOUR   = 8'h07,
  parameter logic [7:0] RST_MIN    = 8'h00
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SIG1HZ,
  input  logic       SIG2HZ,
  input  logic       ALMSET,
  input  logic       SELECT,
  input  logic       ADJUST,
  input  logic       STOP,
  input  logic       ALMEN,
  input  logic [7:0] CUR_HOUR,
  input  logic [7:0] CUR_MIN,
  input  logic [7:0] CUR_SEC,
  output logic [7:0] ALM_HOUR,
  output logic [7:0] ALM_MIN,
  output logic       SHOWALM,
  output logic       AMINON,
  output logic       AHOURON,
  output logic       RINGING,
  output logic       BUZZ
);

  localparam int SNZ_SEC = SNOOZE_MIN * 60;
  localparam int TMAX    = (RING_SEC > SNZ_SEC) ? RING_SEC : SNZ_SEC;
  localparam int TW      = $clog2(TMAX + 1);
  localparam logic [TW-1:0] RING_LD = TW'(RING_SEC);
  localparam logic [TW-1:0] SNZ_LD  = TW'(SNZ_SEC);

  alarm_state_t  state;
  logic          match, match_q, trig, expire;
  logic          t_load, t_zero;
  logic [TW-1:0] t_val, t_count;

  assign match = ALMEN && (CUR_HOUR == ALM_HOUR) && (CUR_MIN == ALM_MIN) && (CUR_SEC == 8'h00);
  assign trig  = match && !match_q;
  // Final second of either phase: the pulse that takes the count from 1 to 0.
  assign expire = SIG1HZ && (t_zero || (t_count == TW'(1)));

  always_comb begin
    t_load = 1'b0;
    t_val  = RING_LD;
    case (state)
      ST_IDLE:   if (!ALMSET && trig) t_load = 1'b1;
      ST_RING:   if (ALMEN && STOP) begin
                   t_load = 1'b1;
                   t_val  = SNZ_LD;
                 end
      ST_SNOOZE: if (ALMEN && !STOP && !ALMSET && expire) t_load = 1'b1;
      default:   ;
    endcase
  end

  alarm_timer #(.W(TW)) u_timer (
    .CLK   (CLK),
    .RST_N (RST_N),
    .LOAD  (t_load),
    .VALUE (t_val),
    .EN    (SIG1HZ),
    .COUNT (t_count),
    .ZERO  (t_zero)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      ALM_HOUR <= RST_HOUR;
      ALM_MIN  <= RST_MIN;
      match_q  <= 1'b0;
    end else begin
      match_q <= match;
      case (state)
        ST_IDLE:
          if (ALMSET)    state <= ST_SETMIN;
          else if (trig) state <= ST_RING;
        ST_SETMIN:
          if (ALMSET)      state   <= ST_IDLE;
          else if (SELECT) state   <= ST_SETHOUR;
          else if (ADJUST) ALM_MIN <= bcd_inc(ALM_MIN, BCD_MIN_MAX);
        ST_SETHOUR:
          if (ALMSET)      state    <= ST_IDLE;
          else if (SELECT) state    <= ST_SETMIN;
          else if (ADJUST) ALM_HOUR <= bcd_inc(ALM_HOUR, BCD_HOUR_MAX);
        ST_RING:
          if (!ALMEN)      state <= ST_IDLE;
          else if (STOP)   state <= ST_SNOOZE;
          else if (expire) state <= ST_IDLE;
        ST_SNOOZE:
          if (STOP || !ALMEN) state <= ST_IDLE;
          else if (ALMSET)    state <= ST_SETMIN;
          else if (expire)    state <= ST_RING;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign SHOWALM = (state == ST_SETMIN) || (state == ST_SETHOUR);
  assign AMINON  = !((state == ST_SETMIN) && SIG2HZ);
  assign AHOURON = !((state == ST_SETHOUR) && SIG2HZ);
  assign RINGING = (state == ST_RING);
  assign BUZZ    = RINGING && SIG2HZ;

endmodule
